instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode type, fetch FSM states
// and the tagged fetch buffer entry.
package cpu_pkg;
    localparam int XLEN  = 16;
    localparam int OPC_W = 2;

    typedef logic [OPC_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic opcode_t opcode_of(input logic [XLEN-1:0] instr);
        return instr[XLEN-1 -: OPC_W];
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched instructions tagged with their fetch address.
// clear_i wins over push/pop in the same cycle.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [XLEN-1:0] push_instr_i,
    input  logic            pop_i,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [1:0]      count_o
);
    fetch_entry_t mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i && !clear_i && (count_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= '{pc: push_pc_i, instr: push_instr_i};
        end
    end

    assign head_pc_o    = mem_q[rd_ptr_q].pc;
    assign head_instr_o = mem_q[rd_ptr_q].instr;
    assign count_o      = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one-cycle-latency memory reads, buffers up to two
// tagged instructions and hands them to decode with valid/ready.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic [1:0]  out_opcode,
    output logic [1:0]  dbg_state_o
);
    // Handshake: an instruction moves to decode on a cycle where out_valid
    // and out_ready are both high at the rising edge; out_* hold while stalled.
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      count;
    logic [2:0]      level;
    logic            pop;

    assign pop   = out_valid && out_ready;
    // Occupancy projected to the end of this cycle; a new request must fit.
    assign level = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        imem_req   = (state_q == FS_RUN) && (level < 3'd2);
        state_d    = state_q;
        case (state_q)
            FS_BOOT:  state_d = FS_RUN;
            FS_RUN:   state_d = FS_RUN;
            FS_FLUSH: state_d = FS_RUN;
            default:  state_d = FS_BOOT;
        endcase
        pc_d       = imem_req ? pc_q + 16'd1 : pc_q;
        req_addr_d = imem_req ? pc_q : req_addr_q;
        inflight_d = imem_req;
        // A redirect kills the request issued this cycle and restarts fetch.
        if (redirect) begin
            state_d    = FS_FLUSH;
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FS_BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (redirect),
        .push_i       (inflight_q),
        .push_pc_i    (req_addr_q),
        .push_instr_i (imem_rdata),
        .pop_i        (pop),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr),
        .count_o      (count)
    );

    assign imem_addr   = pc_q;
    assign out_valid   = (count != 2'd0);
    assign out_opcode  = opcode_of(out_instr);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle-latency memory model and an
// in-order acceptance monitor.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [1:0]  out_opcode;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          req_total = 0;
    int          req_base;
    logic        mon_en = 1'b0;
    logic [15:0] exp_pc = 16'h000A;

    instr_fetch #(.RESET_PC(16'h000A)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata <= mem_word(imem_addr);
            req_total  <= req_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every accepted instruction must be the next address in program order.
    always @(negedge clk) begin
        logic [15:0] w;
        if (mon_en && !reset && !redirect && out_valid && out_ready) begin
            w = mem_word(exp_pc);
            check("acc_pc", {16'h0, out_pc}, {16'h0, exp_pc});
            check("acc_instr", {16'h0, out_instr}, {16'h0, w});
            check("acc_opcode", {30'h0, out_opcode}, {30'h0, w[15:14]});
            exp_pc = exp_pc + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        mon_en    = 1'b0;
        reset     = 1'b1;
        redirect  = 1'b0;
        out_ready = ready;
        tick();
        tick();
        reset  = 1'b0;
        exp_pc = 16'h000A;
        mon_en = 1'b1;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b1;
        tick();
        tick();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_instr", {16'h0, out_instr}, 32'h0);
        check("rst_pc", {16'h0, out_pc}, 32'h0);
        check("rst_opcode", {30'h0, out_opcode}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, {30'h0, FS_BOOT});
        check("rst_addr", {16'h0, imem_addr}, 32'h000A);

        // Streaming from RESET_PC with decode always ready.
        reset  = 1'b0;
        exp_pc = 16'h000A;
        mon_en = 1'b1;
        #1;
        check("boot_req", {31'h0, imem_req}, 32'h0);
        check("boot_state", {30'h0, dbg_state}, {30'h0, FS_BOOT});
        tick();
        check("c2_req", {15'h0, imem_req, imem_addr}, 32'h1000A);
        tick();
        check("c3_req", {15'h0, imem_req, imem_addr}, 32'h1000B);
        check("c3_valid", {31'h0, out_valid}, 32'h0);
        tick();
        check("c4_req", {15'h0, imem_req, imem_addr}, 32'h1000C);
        check("c4_valid", {31'h0, out_valid}, 32'h1);
        check("c4_pc", {16'h0, out_pc}, 32'h000A);
        repeat (3) tick();

        // Decode stalled for six cycles: only two requests fit the buffer.
        do_reset(1'b0);
        req_base = req_total;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i >= 3) begin
                check("stall_valid", {31'h0, out_valid}, 32'h1);
                check("stall_pc", {16'h0, out_pc}, 32'h000A);
                check("stall_instr", {16'h0, out_instr}, {16'h0, mem_word(16'h000A)});
            end
        end
        check("stall_reqs", req_total - req_base, 32'd2);

        // Redirect with two buffered entries and a request issued the same cycle.
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        out_ready   = 1'b1;
        exp_pc      = 16'h0040;
        #1;
        check("rd_kill_req", {31'h0, imem_req}, 32'h1);
        tick();
        redirect = 1'b0;
        #1;
        check("rd_state", {30'h0, dbg_state}, {30'h0, FS_FLUSH});
        check("rd_n1_valid", {31'h0, out_valid}, 32'h0);
        check("rd_n1_req", {31'h0, imem_req}, 32'h0);
        tick();
        check("rd_n2_req", {15'h0, imem_req, imem_addr}, 32'h10040);
        check("rd_n2_valid", {31'h0, out_valid}, 32'h0);
        tick();
        check("rd_n3_valid", {31'h0, out_valid}, 32'h0);
        tick();
        check("rd_n4_valid", {31'h0, out_valid}, 32'h1);
        check("rd_n4_pc", {16'h0, out_pc}, 32'h0040);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sustain_valid", {31'h0, out_valid}, 32'h1);
        end

        // PC wrap from FFFF to 0000.
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        exp_pc      = 16'hFFFF;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_a", {15'h0, imem_req, imem_addr}, 32'h1FFFF);
        tick();
        check("wrap_b", {15'h0, imem_req, imem_addr}, 32'h10000);
        tick();
        check("wrap_pc0", {16'h0, out_pc}, 32'h0000FFFF);
        tick();
        check("wrap_pc1", {16'h0, out_pc}, 32'h00000000);
        tick();

        // Back-to-back redirects: only the second target reaches decode.
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        exp_pc      = 16'h0080;
        tick();
        redirect_pc = 16'h0080;
        #1;
        check("b2b_state", {30'h0, dbg_state}, {30'h0, FS_FLUSH});
        tick();
        redirect = 1'b0;
        #1;
        check("b2b_flush", {30'h0, dbg_state}, {30'h0, FS_FLUSH});
        check("b2b_n2_req", {31'h0, imem_req}, 32'h0);
        tick();
        check("b2b_n3_req", {15'h0, imem_req, imem_addr}, 32'h10080);
        tick();
        check("b2b_n4_valid", {31'h0, out_valid}, 32'h0);
        tick();
        check("b2b_n5_pc", {15'h0, out_valid, out_pc}, 32'h10080);
        repeat (3) tick();

        // Reset mid-operation with one buffered entry and one request in flight.
        do_reset(1'b0);
        tick();
        tick();
        tick();
        check("mid_valid", {31'h0, out_valid}, 32'h1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_pc", {16'h0, out_pc}, 32'h0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        exp_pc    = 16'h000A;
        mon_en    = 1'b1;
        #1;
        check("mid_boot_req", {31'h0, imem_req}, 32'h0);
        check("mid_boot_valid", {31'h0, out_valid}, 32'h0);
        tick();
        check("mid_c2_req", {15'h0, imem_req, imem_addr}, 32'h1000A);
        tick();
        check("mid_c3_valid", {31'h0, out_valid}, 32'h0);
        tick();
        check("mid_c4_pc", {15'h0, out_valid, out_pc}, 32'h1000A);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
